// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command driver: request opcodes,
// response status codes and driver FSM states.
package pq_pkg;

    // Bit 0 selects the queue write strobe, bit 1 the read strobe.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } pq_op_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_FULL    = 2'b01,
        ERR_EMPTY   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } pq_err_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_WAIT_VALID = 2'b01,
        ST_ISSUE      = 2'b10,
        ST_RESP       = 2'b11
    } pq_drv_state_t;

endpackage

// File: rtl/pq_cmd_driver.sv
// Request/response front end for a hybrid-tree priority queue: waits for the
// queue's o_valid settle window, issues one single-cycle command, returns status.
module pq_cmd_driver
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [1:0]            o_rsp_err,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic                  i_pq_valid,
    input  logic [DATA_WIDTH-1:0] i_pq_data
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    pq_drv_state_t         state_reg, state_next;
    pq_op_t                op_reg, op_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [DATA_WIDTH-1:0] res_data_reg, res_data_next;
    pq_err_t               res_err_reg, res_err_next;
    logic [GW-1:0]         guard_reg, guard_next;
    logic [TW-1:0]         tmo_reg, tmo_next;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        data_next     = data_reg;
        res_data_next = res_data_reg;
        res_err_next  = res_err_reg;
        tmo_next      = tmo_reg;
        guard_next    = (guard_reg != '0) ? guard_reg - 1'b1 : '0;

        case (state_reg)
            ST_IDLE: begin
                if (o_req_ready && i_req_valid) begin
                    op_next    = pq_op_t'(i_req_op);
                    data_next  = i_req_data;
                    tmo_next   = '0;
                    state_next = ST_WAIT_VALID;
                end
            end
            ST_WAIT_VALID: begin
                tmo_next = tmo_reg + 1'b1;
                if (guard_reg == '0 && i_pq_valid) begin
                    state_next    = ST_RESP;
                    res_data_next = '0;
                    if (op_reg == OP_NONE) begin
                        res_err_next = ERR_TIMEOUT;
                    end else if (op_reg == OP_PUSH && i_pq_full) begin
                        res_err_next = ERR_FULL;
                    end else if (op_reg == OP_POP && i_pq_empty) begin
                        res_err_next = ERR_EMPTY;
                    end else begin
                        res_err_next = ERR_OK;
                        state_next   = ST_ISSUE;
                        // An empty queue's root is meaningless, so replace reports zero.
                        if (op_reg != OP_PUSH && !i_pq_empty)
                            res_data_next = i_pq_data;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    state_next    = ST_RESP;
                    res_data_next = '0;
                    res_err_next  = ERR_TIMEOUT;
                end
            end
            ST_ISSUE: begin
                guard_next = GUARD_LOAD;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NONE;
            data_reg     <= '0;
            res_data_reg <= '0;
            res_err_reg  <= ERR_OK;
            guard_reg    <= '0;
            tmo_reg      <= '0;
            o_req_ready  <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_err    <= 2'b00;
            o_pq_wrt     <= 1'b0;
            o_pq_read    <= 1'b0;
            o_pq_data    <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            data_reg     <= data_next;
            res_data_reg <= res_data_next;
            res_err_reg  <= res_err_next;
            guard_reg    <= guard_next;
            tmo_reg      <= tmo_next;
            o_req_ready  <= (state_next == ST_IDLE);
            o_rsp_valid  <= (state_next == ST_RESP);
            o_rsp_data   <= (state_next == ST_RESP) ? res_data_next : '0;
            o_rsp_err    <= (state_next == ST_RESP) ? res_err_next : ERR_OK;
            o_pq_wrt     <= (state_next == ST_ISSUE) && op_next[0];
            o_pq_read    <= (state_next == ST_ISSUE) && op_next[1];
            o_pq_data    <= (state_next == ST_ISSUE) ? data_next : '0;
        end
    end

endmodule

// File: tb/tb_pq_cmd_driver.sv
// Directed bench for pq_cmd_driver: table of single transactions against a
// static queue model, plus hand sequences for reset, back-pressure and sift timing.
module tb_pq_cmd_driver;
    import pq_pkg::*;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = 2'b00;
    logic [DW-1:0] i_req_data = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [DW-1:0] o_rsp_data;
    logic [1:0]    o_rsp_err;
    logic          o_pq_wrt;
    logic          o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic          i_pq_full = 1'b0;
    logic          i_pq_empty = 1'b0;
    logic          i_pq_valid = 1'b0;
    logic [DW-1:0] i_pq_data = '0;

    always #5 CLK = ~CLK;

    pq_cmd_driver #(.DATA_WIDTH(DW), .GUARD_CYCLES(2), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty),
        .i_pq_valid(i_pq_valid), .i_pq_data(i_pq_data)
    );

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic          full;
        logic          empty;
        logic          valid;
        logic [DW-1:0] pqd;
        int            ncmd;
        logic          wrt;
        logic          rd;
        logic [DW-1:0] cmd_data;
        int            rsp_cyc;
        logic [DW-1:0] rsp_data;
        logic [1:0]    err;
    } vec_t;

    typedef struct {
        int            ncmd;
        int            cmd_cyc;
        logic          wrt;
        logic          rd;
        logic [DW-1:0] cmd_data;
        int            rsp_cyc;
        logic [DW-1:0] rsp_data;
        logic [1:0]    err;
        logic          ready_after;
    } res_t;

    int checks = 0;
    int failures = 0;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (o_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic do_txn(input vec_t v, output res_t r);
        bit ok;
        r = '{ncmd: 0, cmd_cyc: -1, wrt: 1'b0, rd: 1'b0, cmd_data: '0,
              rsp_cyc: -1, rsp_data: '0, err: 2'b00, ready_after: 1'b0};
        i_pq_full  = v.full;
        i_pq_empty = v.empty;
        i_pq_valid = v.valid;
        i_pq_data  = v.pqd;
        wait_ready(ok);
        chk("req_ready_wait", 32'(ok), 32'd1);
        i_req_valid = 1'b1;
        i_req_op    = v.op;
        i_req_data  = v.data;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            i_req_valid = 1'b0;
            if (o_pq_wrt || o_pq_read) begin
                r.ncmd++;
                r.cmd_cyc  = k;
                r.wrt      = o_pq_wrt;
                r.rd       = o_pq_read;
                r.cmd_data = o_pq_data;
            end
            if (o_rsp_valid) begin
                r.rsp_cyc  = k;
                r.rsp_data = o_rsp_data;
                r.err      = o_rsp_err;
                break;
            end
        end
        @(negedge CLK);
        r.ready_after = o_req_ready;
    endtask

    initial begin
        res_t r;
        bit ok;
        int reads, rsps, drop_cnt, back_cyc, read2_cyc, req2_state;
        logic [DW-1:0] rsp1, rsp2;

        //          op          data      full  empty valid pqd      | ncmd wrt  rd   cmd_data rsp rsp_data err
        vecs[0] = '{OP_PUSH,    16'h0005, 1'b0, 1'b0, 1'b1, 16'h0099, 1, 1'b1, 1'b0, 16'h0005, 3, 16'h0000, 2'b00};
        vecs[1] = '{OP_POP,     16'h1111, 1'b0, 1'b0, 1'b1, 16'h0042, 1, 1'b0, 1'b1, 16'h1111, 3, 16'h0042, 2'b00};
        vecs[2] = '{OP_POP,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0042, 0, 1'b0, 1'b0, 16'h0000, 2, 16'h0000, 2'b10};
        vecs[3] = '{OP_PUSH,    16'h00AA, 1'b1, 1'b0, 1'b1, 16'h0042, 0, 1'b0, 1'b0, 16'h0000, 2, 16'h0000, 2'b01};
        vecs[4] = '{OP_REPLACE, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h0003, 1, 1'b1, 1'b1, 16'h0007, 3, 16'h0003, 2'b00};
        vecs[5] = '{OP_REPLACE, 16'h0009, 1'b0, 1'b1, 1'b1, 16'h0055, 1, 1'b1, 1'b1, 16'h0009, 3, 16'h0000, 2'b00};
        vecs[6] = '{OP_NONE,    16'h0123, 1'b0, 1'b0, 1'b1, 16'h0042, 0, 1'b0, 1'b0, 16'h0000, 2, 16'h0000, 2'b11};
        vecs[7] = '{OP_PUSH,    16'h0BEE, 1'b0, 1'b0, 1'b0, 16'h0042, 0, 1'b0, 1'b0, 16'h0000, 17, 16'h0000, 2'b11};
        vecs[8] = '{OP_POP,     16'h2222, 1'b1, 1'b0, 1'b1, 16'hABCD, 1, 1'b0, 1'b1, 16'h2222, 3, 16'hABCD, 2'b00};

        // Reset held for three cycles: every output low throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_outputs", {o_req_ready, o_rsp_valid, o_pq_wrt, o_pq_read, o_rsp_err},
                32'd0);
            chk("rst_data", {o_rsp_data, o_pq_data}, 32'd0);
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(o_req_ready), 32'd1);
        $display("txn reset: ready=%0d", o_req_ready);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], r);
            $display("txn %0d: op=%0d ncmd=%0d cmd_cyc=%0d rsp_cyc=%0d data=%h err=%0d",
                     i, vecs[i].op, r.ncmd, r.cmd_cyc, r.rsp_cyc, r.rsp_data, r.err);
            chk($sformatf("v%0d_ncmd", i), 32'(r.ncmd), 32'(vecs[i].ncmd));
            if (vecs[i].ncmd == 1) begin
                chk($sformatf("v%0d_cmd_cyc", i), 32'(r.cmd_cyc), 32'd2);
                chk($sformatf("v%0d_wrt_rd", i), {r.wrt, r.rd}, {vecs[i].wrt, vecs[i].rd});
                chk($sformatf("v%0d_cmd_data", i), 32'(r.cmd_data), 32'(vecs[i].cmd_data));
            end
            chk($sformatf("v%0d_rsp_cyc", i), 32'(r.rsp_cyc), 32'(vecs[i].rsp_cyc));
            chk($sformatf("v%0d_rsp_data", i), 32'(r.rsp_data), 32'(vecs[i].rsp_data));
            chk($sformatf("v%0d_rsp_err", i), 32'(r.err), 32'(vecs[i].err));
            chk($sformatf("v%0d_ready_after", i), 32'(r.ready_after), 32'd1);
        end

        // Response back-pressure: data and status hold while i_rsp_ready is low.
        i_pq_full = 1'b0; i_pq_empty = 1'b0; i_pq_valid = 1'b1; i_pq_data = 16'h0077;
        i_rsp_ready = 1'b0;
        wait_ready(ok);
        chk("hold_ready_wait", 32'(ok), 32'd1);
        i_req_valid = 1'b1; i_req_op = OP_POP; i_req_data = 16'h0000;
        for (int k = 0; k < 10 && !o_rsp_valid; k++) begin
            @(negedge CLK);
            i_req_valid = 1'b0;
        end
        i_pq_data = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("hold_rsp_valid", {o_rsp_valid, o_req_ready}, 32'b10);
            chk("hold_rsp_data", 32'(o_rsp_data), 32'h0077);
            chk("hold_rsp_err", 32'(o_rsp_err), 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(negedge CLK);
        chk("hold_release", {o_rsp_valid, o_req_ready}, 32'b01);
        $display("txn hold: released, ready=%0d", o_req_ready);

        // Back-to-back pops; the queue model drops o_valid for 6 cycles after each command.
        i_pq_data = 16'h0040; i_pq_valid = 1'b1;
        reads = 0; rsps = 0; drop_cnt = 0; back_cyc = -1; read2_cyc = -1;
        rsp1 = '0; rsp2 = '0; req2_state = 0;
        i_req_valid = 1'b1; i_req_op = OP_POP; i_req_data = 16'h0000;
        for (int k = 1; k <= 60 && rsps < 2; k++) begin
            @(negedge CLK);
            if (req2_state == 1) begin
                i_req_valid = 1'b0;
                req2_state = 2;
            end
            if (k == 1) i_req_valid = 1'b0;
            if (o_pq_read) begin
                reads++;
                if (reads == 2) read2_cyc = k;
                drop_cnt = 6;
                i_pq_valid = 1'b0;
            end else if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) begin
                    i_pq_valid = 1'b1;
                    i_pq_data = 16'h0030;
                    back_cyc = k;
                end
            end
            if (o_rsp_valid) begin
                rsps++;
                if (rsps == 1) rsp1 = o_rsp_data;
                else rsp2 = o_rsp_data;
            end
            if (o_req_ready && rsps == 1 && req2_state == 0) begin
                i_req_valid = 1'b1;
                req2_state = 1;
            end
        end
        $display("txn b2b: reads=%0d back_cyc=%0d read2_cyc=%0d rsp1=%h rsp2=%h",
                 reads, back_cyc, read2_cyc, rsp1, rsp2);
        chk("b2b_rsps", 32'(rsps), 32'd2);
        chk("b2b_reads", 32'(reads), 32'd2);
        chk("b2b_read2_cyc", 32'(read2_cyc), 32'(back_cyc + 1));
        chk("b2b_rsp1", 32'(rsp1), 32'h0040);
        chk("b2b_rsp2", 32'(rsp2), 32'h0030);
        repeat (8) @(negedge CLK);
        i_pq_valid = 1'b1;

        // Reset during ISSUE: pulse is cut and no response follows.
        i_pq_data = 16'h0011;
        wait_ready(ok);
        chk("rst_issue_ready_wait", 32'(ok), 32'd1);
        i_req_valid = 1'b1; i_req_op = OP_POP; i_req_data = 16'h0000;
        @(negedge CLK);
        i_req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_issue_pulse", 32'(o_pq_read), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_issue_ctrl", {o_req_ready, o_rsp_valid, o_pq_wrt, o_pq_read, o_rsp_err},
            32'd0);
        chk("rst_issue_data", {o_rsp_data, o_pq_data}, 32'd0);
        RST = 1'b0;
        rsps = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (o_rsp_valid || o_pq_read || o_pq_wrt) rsps++;
        end
        chk("rst_issue_no_rsp", 32'(rsps), 32'd0);
        chk("rst_issue_ready", 32'(o_req_ready), 32'd1);
        $display("txn rst_in_issue: ready=%0d stray=%0d", o_req_ready, rsps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
